// File: rtl/pe_affine.sv
// Affine-gap (Gotoh) systolic processing element for Smith-Waterman / Needleman-Wunsch arrays.
// One DP cell per enabled cycle. H/E/F, the traceback pointer and the running maximum are all registered.

module pe_affine #(
   parameter  int LEN1     = 5,
   parameter  int LEN2     = 5,
   parameter  int SCORE_W  = 16,
   parameter  int PEN_W    = 8,
   parameter  int ALPHABET = 0,
   parameter  int BASE_W   = 5,
   localparam int ROW_W    = $clog2(LEN1) + 1,
   localparam int COL_W    = $clog2(LEN2) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      valid_col,
   input  logic                      mode_local,
   input  logic [PEN_W-1:0]          gap_open,
   input  logic [PEN_W-1:0]          gap_ext,
   input  logic [PEN_W-1:0]          match_score,
   input  logic [PEN_W-1:0]          mismatch_pen,
   input  logic signed [SCORE_W-1:0] h_bound,
   input  logic [BASE_W-1:0]         seq1,
   input  logic [BASE_W-1:0]         seq2,
   input  logic signed [SCORE_W-1:0] h_left,
   input  logic signed [SCORE_W-1:0] f_left,
   input  logic [ROW_W-1:0]          rowId_in,
   input  logic [COL_W-1:0]          colId_in,
   input  logic [ROW_W-1:0]          maxRowId_in,
   input  logic [COL_W-1:0]          maxColId_in,
   input  logic signed [SCORE_W-1:0] max_h_in,
   output logic                      enable_out,
   output logic [BASE_W-1:0]         seq1_out,
   output logic [ROW_W-1:0]          rowId_out,
   output logic signed [SCORE_W-1:0] h_out,
   output logic signed [SCORE_W-1:0] f_out,
   output logic [1:0]                pointer_out,
   output logic                      e_ext,
   output logic                      f_ext,
   output logic signed [SCORE_W-1:0] max_h_out,
   output logic [ROW_W-1:0]          maxRowId_out,
   output logic [COL_W-1:0]          maxColId_out
);
   localparam int EXT_W = SCORE_W + 2;

   typedef logic signed [SCORE_W-1:0] score_t;
   typedef logic signed [EXT_W-1:0]   wide_t;
   typedef enum logic [1:0] {PTR_NIL = 2'd0, PTR_DIAG = 2'd1, PTR_LEFT = 2'd2, PTR_ABOVE = 2'd3} ptr_t;

   localparam score_t NEG_INF = {2'b11, {(SCORE_W-2){1'b0}}};
   localparam score_t POS_MAX = {1'b0, {(SCORE_W-1){1'b1}}};

   // NOTE: NEG_INF sits at a quarter of the range so that NEG_INF minus a penalty still fits in EXT_W bits before clamping.
   function automatic score_t sat(input wide_t x);
      if (x < wide_t'(NEG_INF)) return NEG_INF;
      if (x > wide_t'(POS_MAX)) return POS_MAX;
      return score_t'(x);
   endfunction

   score_t h_diag, e_reg;
   ptr_t   ptr_q;
   score_t s_prot;
   wide_t  s_w;
   score_t d_val, e_ext_term, e_open_term, f_ext_term, f_open_term, e_new, f_new, h_new;
   ptr_t   ptr_new;
   score_t mx_h;
   logic [ROW_W-1:0] mx_row;
   logic [COL_W-1:0] mx_col;

   blosum_compare #(.BASE_W(BASE_W), .SCORE_W(SCORE_W)) u_blosum (
      .a(seq1),
      .b(seq2),
      .s(s_prot)
   );

   always_comb begin
      if (ALPHABET == 1)       s_w = wide_t'(s_prot);
      else if (seq1 == seq2)   s_w = wide_t'(match_score);
      else                     s_w = -wide_t'(mismatch_pen);

      d_val       = sat(wide_t'(h_diag) + s_w);
      e_ext_term  = sat(wide_t'(e_reg)  - wide_t'(gap_ext));
      e_open_term = sat(wide_t'(h_out)  - wide_t'(gap_open));
      f_ext_term  = sat(wide_t'(f_left) - wide_t'(gap_ext));
      f_open_term = sat(wide_t'(h_left) - wide_t'(gap_open));
      e_new = (e_ext_term > e_open_term) ? e_ext_term : e_open_term;
      f_new = (f_ext_term > f_open_term) ? f_ext_term : f_open_term;

      // Strict comparisons give Diagonal > Above > Left on ties.
      h_new   = d_val;
      ptr_new = PTR_DIAG;
      if (e_new > h_new) begin h_new = e_new; ptr_new = PTR_ABOVE; end
      if (f_new > h_new) begin h_new = f_new; ptr_new = PTR_LEFT;  end
      if (mode_local && h_new <= score_t'(0)) begin
         h_new   = '0;
         ptr_new = PTR_NIL;
      end

      mx_h   = max_h_out;
      mx_row = maxRowId_out;
      mx_col = maxColId_out;
      if (max_h_in > mx_h) begin
         mx_h = max_h_in; mx_row = maxRowId_in; mx_col = maxColId_in;
      end
      if (enable && valid_col && h_new > mx_h) begin
         mx_h = h_new; mx_row = rowId_in; mx_col = colId_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_out        <= '0;
         f_out        <= NEG_INF;
         e_reg        <= NEG_INF;
         h_diag       <= NEG_INF;
         ptr_q        <= PTR_NIL;
         e_ext        <= 1'b0;
         f_ext        <= 1'b0;
         enable_out   <= 1'b0;
         seq1_out     <= '0;
         rowId_out    <= '0;
         max_h_out    <= '0;
         maxRowId_out <= '0;
         maxColId_out <= '0;
      end else begin
         h_diag       <= h_left;
         enable_out   <= enable;
         seq1_out     <= seq1;
         rowId_out    <= rowId_in;
         max_h_out    <= mx_h;
         maxRowId_out <= mx_row;
         maxColId_out <= mx_col;
         if (enable) begin
            h_out <= h_new;
            e_reg <= e_new;
            f_out <= f_new;
            ptr_q <= ptr_new;
            e_ext <= e_ext_term > e_open_term;
            f_ext <= f_ext_term > f_open_term;
         end else begin
            h_out <= mode_local ? score_t'(0) : h_bound;
            e_reg <= NEG_INF;
            f_out <= NEG_INF;
            ptr_q <= PTR_NIL;
            e_ext <= 1'b0;
            f_ext <= 1'b0;
         end
      end
   end

   assign pointer_out = ptr_q;

endmodule

// BLOSUM50 substitution lookup; residue order A R N D C Q E G H I L K M F P S T W Y V, other codes score -5.
module blosum_compare #(
   parameter int BASE_W  = 5,
   parameter int SCORE_W = 16
) (
   input  logic [BASE_W-1:0]         a,
   input  logic [BASE_W-1:0]         b,
   output logic signed [SCORE_W-1:0] s
);
   localparam int TBL [20][20] = '{
      '{ 5,-2,-1,-2,-1,-1,-1, 0,-2,-1,-2,-1,-1,-3,-1, 1, 0,-3,-2, 0},
      '{-2, 7,-1,-2,-4, 1, 0,-3, 0,-4,-3, 3,-2,-3,-3,-1,-1,-3,-1,-3},
      '{-1,-1, 7, 2,-2, 0, 0, 0, 1,-3,-4, 0,-2,-4,-2, 1, 0,-4,-2,-3},
      '{-2,-2, 2, 8,-4, 0, 2,-1,-1,-4,-4,-1,-4,-5,-1, 0,-1,-5,-3,-4},
      '{-1,-4,-2,-4,13,-3,-3,-3,-3,-2,-2,-3,-2,-2,-4,-1,-1,-5,-3,-1},
      '{-1, 1, 0, 0,-3, 7, 2,-2, 1,-3,-2, 2, 0,-4,-1, 0,-1,-1,-1,-3},
      '{-1, 0, 0, 2,-3, 2, 6,-3, 0,-4,-3, 1,-2,-3,-1,-1,-1,-3,-2,-3},
      '{ 0,-3, 0,-1,-3,-2,-3, 8,-2,-4,-4,-2,-3,-4,-2, 0,-2,-3,-3,-4},
      '{-2, 0, 1,-1,-3, 1, 0,-2,10,-4,-3, 0,-1,-1,-2,-1,-2,-3, 2,-4},
      '{-1,-4,-3,-4,-2,-3,-4,-4,-4, 5, 2,-3, 2, 0,-3,-3,-1,-3,-1, 4},
      '{-2,-3,-4,-4,-2,-2,-3,-4,-3, 2, 5,-3, 3, 1,-4,-3,-1,-2,-1, 1},
      '{-1, 3, 0,-1,-3, 2, 1,-2, 0,-3,-3, 6,-2,-4,-1, 0,-1,-3,-2,-3},
      '{-1,-2,-2,-4,-2, 0,-2,-3,-1, 2, 3,-2, 7, 0,-3,-2,-1,-1, 0, 1},
      '{-3,-3,-4,-5,-2,-4,-3,-4,-1, 0, 1,-4, 0, 8,-4,-3,-2, 1, 4,-1},
      '{-1,-3,-2,-1,-4,-1,-1,-2,-2,-3,-4,-1,-3,-4,10,-1,-1,-4,-3,-3},
      '{ 1,-1, 1, 0,-1, 0,-1, 0,-1,-3,-3, 0,-2,-3,-1, 5, 2,-4,-2,-2},
      '{ 0,-1, 0,-1,-1,-1,-1,-2,-2,-1,-1,-1,-1,-2,-1, 2, 5,-3,-2, 0},
      '{-3,-3,-4,-5,-5,-1,-3,-3,-3,-3,-2,-3,-1, 1,-4,-4,-3,15, 2,-3},
      '{-2,-1,-2,-3,-3,-1,-2,-3, 2,-1,-1,-2, 0, 4,-3,-2,-2, 2, 8,-1},
      '{ 0,-3,-3,-4,-1,-3,-3,-4,-4, 4, 1,-3, 1,-1,-3,-2, 0,-3,-1, 5}
   };

   always_comb begin
      s = SCORE_W'(-5);
      if (int'(a) < 20 && int'(b) < 20) s = SCORE_W'(TBL[a][b]);
   end

endmodule

// File: tb/tb_pe_affine.sv
// Directed bench for pe_affine: a DNA instance and a protein (BLOSUM50) instance share one stimulus.
`timescale 1ns/1ps

module tb_pe_affine;
   localparam int SCORE_W = 16;
   localparam int PEN_W   = 8;
   localparam int BASE_W  = 5;
   localparam int ROW_W   = 4;
   localparam int COL_W   = 4;
   localparam logic signed [SCORE_W-1:0] NEG_INF = -16'sd16384;

   logic clk = 1'b0;
   logic rst;
   logic enable, valid_col, mode_local;
   logic [PEN_W-1:0] gap_open, gap_ext, match_score, mismatch_pen;
   logic signed [SCORE_W-1:0] h_bound, h_left, f_left, max_h_in;
   logic [BASE_W-1:0] seq1, seq2;
   logic [ROW_W-1:0]  rowId_in, maxRowId_in;
   logic [COL_W-1:0]  colId_in, maxColId_in;

   logic enable_out, e_ext, f_ext;
   logic [BASE_W-1:0] seq1_out;
   logic [ROW_W-1:0]  rowId_out, maxRowId_out;
   logic [COL_W-1:0]  maxColId_out;
   logic signed [SCORE_W-1:0] h_out, f_out, max_h_out;
   logic [1:0] pointer_out;

   logic p_enable_out, p_e_ext, p_f_ext;
   logic [BASE_W-1:0] p_seq1_out;
   logic [ROW_W-1:0]  p_rowId_out, p_maxRowId_out;
   logic [COL_W-1:0]  p_maxColId_out;
   logic signed [SCORE_W-1:0] p_h_out, p_f_out, p_max_h_out;
   logic [1:0] p_pointer_out;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pe_affine #(.SCORE_W(SCORE_W), .PEN_W(PEN_W), .ALPHABET(0), .BASE_W(BASE_W)) u_dna (
      .clk(clk), .rst(rst), .enable(enable), .valid_col(valid_col), .mode_local(mode_local),
      .gap_open(gap_open), .gap_ext(gap_ext), .match_score(match_score), .mismatch_pen(mismatch_pen),
      .h_bound(h_bound), .seq1(seq1), .seq2(seq2), .h_left(h_left), .f_left(f_left),
      .rowId_in(rowId_in), .colId_in(colId_in), .maxRowId_in(maxRowId_in), .maxColId_in(maxColId_in),
      .max_h_in(max_h_in), .enable_out(enable_out), .seq1_out(seq1_out), .rowId_out(rowId_out),
      .h_out(h_out), .f_out(f_out), .pointer_out(pointer_out), .e_ext(e_ext), .f_ext(f_ext),
      .max_h_out(max_h_out), .maxRowId_out(maxRowId_out), .maxColId_out(maxColId_out)
   );

   pe_affine #(.SCORE_W(SCORE_W), .PEN_W(PEN_W), .ALPHABET(1), .BASE_W(BASE_W)) u_prot (
      .clk(clk), .rst(rst), .enable(enable), .valid_col(valid_col), .mode_local(mode_local),
      .gap_open(gap_open), .gap_ext(gap_ext), .match_score(match_score), .mismatch_pen(mismatch_pen),
      .h_bound(h_bound), .seq1(seq1), .seq2(seq2), .h_left(h_left), .f_left(f_left),
      .rowId_in(rowId_in), .colId_in(colId_in), .maxRowId_in(maxRowId_in), .maxColId_in(maxColId_in),
      .max_h_in(max_h_in), .enable_out(p_enable_out), .seq1_out(p_seq1_out), .rowId_out(p_rowId_out),
      .h_out(p_h_out), .f_out(p_f_out), .pointer_out(p_pointer_out), .e_ext(p_e_ext), .f_ext(p_f_ext),
      .max_h_out(p_max_h_out), .maxRowId_out(p_maxRowId_out), .maxColId_out(p_maxColId_out)
   );

   // Outputs are sampled 1 ns after the rising edge; inputs change at that point too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      enable = 1'b0; valid_col = 1'b0;
      h_left = '0; f_left = NEG_INF; max_h_in = '0;
      maxRowId_in = '0; maxColId_in = '0; rowId_in = '0; colId_in = '0;
      seq1 = '0; seq2 = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (h_out !== 16'sd0) begin n_fail++; $display("FAIL rst_h_out: got %0d want 0", h_out); end
      n_cmp++; if (f_out !== NEG_INF) begin n_fail++; $display("FAIL rst_f_out: got %0d want -16384", f_out); end
      n_cmp++; if (pointer_out !== 2'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d want 0", pointer_out); end
      n_cmp++; if ({e_ext, f_ext, enable_out} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {e_ext, f_ext, enable_out}); end
      n_cmp++; if (max_h_out !== 16'sd0 || maxRowId_out !== 4'd0 || maxColId_out !== 4'd0) begin
         n_fail++; $display("FAIL rst_max: got %0d/%0d/%0d want 0/0/0", max_h_out, maxRowId_out, maxColId_out); end

      // Build h_out = 9 (h_diag 7 + match 2), then reset between edges.
      rst = 1'b0;
      idle_inputs(); h_left = 16'sd7; tick();
      enable = 1'b1; valid_col = 1'b1; seq1 = 5'd1; seq2 = 5'd1; h_left = 16'sd0;
      rowId_in = 4'd2; colId_in = 4'd3; tick();
      n_cmp++; if (h_out !== 16'sd9) begin n_fail++; $display("FAIL pre_rst_h: got %0d want 9", h_out); end
      n_cmp++; if (max_h_out !== 16'sd9) begin n_fail++; $display("FAIL pre_rst_max: got %0d want 9", max_h_out); end
      n_cmp++; if (enable_out !== 1'b1) begin n_fail++; $display("FAIL pre_rst_en: got %b want 1", enable_out); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (h_out !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_h: got %0d want 0", h_out); end
      n_cmp++; if (max_h_out !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_max: got %0d want 0", max_h_out); end
      n_cmp++; if (enable_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %b want 0", enable_out); end
      n_cmp++; if (f_out !== NEG_INF) begin n_fail++; $display("FAIL mid_rst_f: got %0d want -16384", f_out); end
      n_cmp++; if (pointer_out !== 2'd0) begin n_fail++; $display("FAIL mid_rst_ptr: got %0d want 0", pointer_out); end
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_dna_match();
      apply_reset();
      h_left = 16'sd5; tick();
      enable = 1'b1; seq1 = 5'd2; seq2 = 5'd2; h_left = NEG_INF; f_left = NEG_INF; tick();
      n_cmp++; if (h_out !== 16'sd7) begin n_fail++; $display("FAIL dna_h: got %0d want 7", h_out); end
      n_cmp++; if (pointer_out !== 2'd1) begin n_fail++; $display("FAIL dna_ptr: got %0d want 1", pointer_out); end
      n_cmp++; if (f_out !== NEG_INF) begin n_fail++; $display("FAIL dna_f_floor: got %0d want -16384", f_out); end
      n_cmp++; if ({e_ext, f_ext} !== 2'b00) begin n_fail++; $display("FAIL dna_ext: got %b want 00", {e_ext, f_ext}); end
   endtask

   task automatic test_affine_ext();
      int exp_h [3] = '{7, 6, 5};
      logic exp_e [3] = '{1'b0, 1'b1, 1'b1};
      apply_reset();
      h_left = 16'sd8; tick();
      enable = 1'b1; seq1 = 5'd1; seq2 = 5'd1; h_left = 16'sd0; tick();
      n_cmp++; if (h_out !== 16'sd10) begin n_fail++; $display("FAIL aff_seed_h: got %0d want 10", h_out); end
      seq2 = 5'd2; h_left = NEG_INF;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (h_out !== 16'(exp_h[i])) begin n_fail++; $display("FAIL aff_h[%0d]: got %0d want %0d", i, h_out, exp_h[i]); end
         n_cmp++; if (pointer_out !== 2'd3) begin n_fail++; $display("FAIL aff_ptr[%0d]: got %0d want 3", i, pointer_out); end
         n_cmp++; if (e_ext !== exp_e[i]) begin n_fail++; $display("FAIL aff_e_ext[%0d]: got %b want %b", i, e_ext, exp_e[i]); end
      end
   endtask

   task automatic test_mode();
      apply_reset();
      tick();
      enable = 1'b1; seq1 = 5'd1; seq2 = 5'd2; h_left = 16'sd0; tick();
      n_cmp++; if (h_out !== 16'sd0) begin n_fail++; $display("FAIL local_h: got %0d want 0", h_out); end
      n_cmp++; if (pointer_out !== 2'd0) begin n_fail++; $display("FAIL local_ptr: got %0d want 0", pointer_out); end
      // Global: idle loads the boundary, left neighbour also presents its boundary (-3); E and F tie at -6.
      mode_local = 1'b0; h_bound = -16'sd3;
      idle_inputs(); h_left = NEG_INF; tick();
      n_cmp++; if (h_out !== -16'sd3) begin n_fail++; $display("FAIL global_bound: got %0d want -3", h_out); end
      enable = 1'b1; seq1 = 5'd1; seq2 = 5'd2; h_left = -16'sd3; tick();
      n_cmp++; if (h_out !== -16'sd6) begin n_fail++; $display("FAIL global_h: got %0d want -6", h_out); end
      n_cmp++; if (pointer_out !== 2'd3) begin n_fail++; $display("FAIL global_ptr: got %0d want 3", pointer_out); end
      mode_local = 1'b1; h_bound = '0;
   endtask

   task automatic test_saturation();
      apply_reset();
      h_left = 16'sd32766; tick();
      enable = 1'b1; seq1 = 5'd3; seq2 = 5'd3; h_left = NEG_INF; tick();
      n_cmp++; if (h_out !== 16'sd32767) begin n_fail++; $display("FAIL sat_high: got %0d want 32767", h_out); end
      n_cmp++; if (f_out !== NEG_INF) begin n_fail++; $display("FAIL sat_low_f: got %0d want -16384", f_out); end
   endtask

   task automatic test_max_tie();
      apply_reset();
      // A: upstream max 8 @ (1,1) takes over from 0; own cell scores 3 via Left but is not in a valid column.
      enable = 1'b1; seq1 = 5'd1; seq2 = 5'd1; h_left = 16'sd6;
      max_h_in = 16'sd8; maxRowId_in = 4'd1; maxColId_in = 4'd1; tick();
      n_cmp++; if (h_out !== 16'sd3 || pointer_out !== 2'd2) begin n_fail++; $display("FAIL max_a_cell: got %0d/%0d want 3/2", h_out, pointer_out); end
      n_cmp++; if (max_h_out !== 16'sd8 || maxRowId_out !== 4'd1 || maxColId_out !== 4'd1) begin
         n_fail++; $display("FAIL max_a: got %0d@(%0d,%0d) want 8@(1,1)", max_h_out, maxRowId_out, maxColId_out); end
      // B: three-way tie at 8, own max keeps its ids.
      h_left = 16'sd7; valid_col = 1'b1; maxRowId_in = 4'd2; maxColId_in = 4'd2;
      rowId_in = 4'd3; colId_in = 4'd3; tick();
      n_cmp++; if (h_out !== 16'sd8) begin n_fail++; $display("FAIL max_b_cell: got %0d want 8", h_out); end
      n_cmp++; if (max_h_out !== 16'sd8 || maxRowId_out !== 4'd1 || maxColId_out !== 4'd1) begin
         n_fail++; $display("FAIL max_tie: got %0d@(%0d,%0d) want 8@(1,1)", max_h_out, maxRowId_out, maxColId_out); end
      // C: new cell scores 9 and wins.
      h_left = NEG_INF; seq1 = 5'd3; seq2 = 5'd3; rowId_in = 4'd4; colId_in = 4'd2; tick();
      n_cmp++; if (max_h_out !== 16'sd9 || maxRowId_out !== 4'd4 || maxColId_out !== 4'd2) begin
         n_fail++; $display("FAIL max_new: got %0d@(%0d,%0d) want 9@(4,2)", max_h_out, maxRowId_out, maxColId_out); end
      n_cmp++; if (rowId_out !== 4'd4 || seq1_out !== 5'd3 || enable_out !== 1'b1) begin
         n_fail++; $display("FAIL fwd: got row %0d seq %0d en %b want 4 3 1", rowId_out, seq1_out, enable_out); end
      // D: idle still merges the upstream max.
      idle_inputs(); max_h_in = 16'sd20; maxRowId_in = 4'd3; maxColId_in = 4'd1; tick();
      n_cmp++; if (max_h_out !== 16'sd20 || maxRowId_out !== 4'd3 || maxColId_out !== 4'd1) begin
         n_fail++; $display("FAIL max_idle: got %0d@(%0d,%0d) want 20@(3,1)", max_h_out, maxRowId_out, maxColId_out); end
      n_cmp++; if (h_out !== 16'sd0 || pointer_out !== 2'd0 || enable_out !== 1'b0) begin
         n_fail++; $display("FAIL idle_cell: got h %0d ptr %0d en %b want 0 0 0", h_out, pointer_out, enable_out); end
   endtask

   task automatic test_protein();
      apply_reset();
      tick();
      enable = 1'b1; seq1 = 5'd17; seq2 = 5'd17; h_left = NEG_INF; tick();
      n_cmp++; if (p_h_out !== 16'sd15) begin n_fail++; $display("FAIL prot_ww: got %0d want 15", p_h_out); end
      n_cmp++; if (p_pointer_out !== 2'd1) begin n_fail++; $display("FAIL prot_ptr: got %0d want 1", p_pointer_out); end
      n_cmp++; if (h_out !== 16'sd2) begin n_fail++; $display("FAIL prot_dna_side: got %0d want 2", h_out); end
      // W vs C scores -5: 10 - 5 = 5.
      idle_inputs(); h_left = 16'sd10; tick();
      enable = 1'b1; seq1 = 5'd17; seq2 = 5'd4; h_left = NEG_INF; tick();
      n_cmp++; if (p_h_out !== 16'sd5) begin n_fail++; $display("FAIL prot_wc: got %0d want 5", p_h_out); end
      n_cmp++; if (h_out !== 16'sd9) begin n_fail++; $display("FAIL dna_mismatch: got %0d want 9", h_out); end
      // A vs R scores -2: 10 - 2 = 8.
      idle_inputs(); h_left = 16'sd10; tick();
      enable = 1'b1; seq1 = 5'd0; seq2 = 5'd1; h_left = NEG_INF; tick();
      n_cmp++; if (p_h_out !== 16'sd8) begin n_fail++; $display("FAIL prot_ar: got %0d want 8", p_h_out); end
   endtask

   initial begin
      rst = 1'b1;
      mode_local = 1'b1; h_bound = '0;
      gap_open = 8'd3; gap_ext = 8'd1; match_score = 8'd2; mismatch_pen = 8'd1;
      idle_inputs();
      #1;
      test_reset();
      test_dna_match();
      test_affine_ext();
      test_mode();
      test_saturation();
      test_max_tie();
      test_protein();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_affine.md
Name: pe_affine

Overview:
- Next-generation systolic processing element for the Smith-Waterman/Needleman-Wunsch array.
- Computes one DP cell per enabled cycle using affine gaps (Gotoh H/E/F recurrences).
- Score width, alphabet, global/local mode and penalties are parametrised or configurable at runtime.
- Instances chain left-to-right: seq1 streams through the chain; each PE holds its own seq2 base. Running maximum and traceback pointers pass out to the array controller and traceback memory.

Parameters:
LEN1, 5, max seq1 length; ROW_W = $clog2(LEN1)+1
LEN2, 5, max seq2 length; COL_W = $clog2(LEN2)+1
SCORE_W, 16, signed score width
PEN_W, 8, unsigned penalty/score config width
ALPHABET, 0, 0 = DNA match/mismatch compare (seq_compare semantics with runtime values); 1 = protein, scored by instantiated blosum_compare
BASE_W, 5, base encoding width

Ports:
clk  in  1  clock
rst  in  1  reset
enable  in  1  cell-compute strobe from left neighbour/controller
valid_col  in  1  current cell lies inside seq2 bounds (eligible for max)
mode_local  in  1  1 = local (zero floor), 0 = global
gap_open  in  PEN_W  cost of first gap cell
gap_ext  in  PEN_W  cost of each further gap cell
match_score  in  PEN_W  DNA match gain
mismatch_pen  in  PEN_W  DNA mismatch cost
h_bound  in  SCORE_W  global-mode boundary H loaded while idle
seq1  in  BASE_W  streaming base
seq2  in  BASE_W  this PE's fixed base
h_left  in  SCORE_W  H from left PE
f_left  in  SCORE_W  F from left PE
rowId_in  in  ROW_W; colId_in  in  COL_W  cell coordinates
maxRowId_in  in  ROW_W; maxColId_in  in  COL_W; max_h_in  in  SCORE_W  upstream running max
enable_out  out  1; seq1_out  out  BASE_W; rowId_out  out  ROW_W  forwarded, one-cycle delay
h_out  out  SCORE_W; f_out  out  SCORE_W  this cell's H and F
pointer_out  out  2  direction {Nil, Diagonal, Left, Above}
e_ext  out  1; f_ext  out  1  gap-extension flags for traceback
max_h_out  out  SCORE_W; maxRowId_out  out  ROW_W; maxColId_out  out  COL_W

Behaviour:
- The clock port is clk. Reset port rst is asynchronous and active-high.
- All outputs are registered. Latency is 1 cycle per cell.
- Reset values: h_out = 0; f_out = NEG_INF; internal e_reg = NEG_INF; h_diag = NEG_INF; pointer_out = Nil; e_ext = f_ext = 0; enable_out = 0; seq1_out = 0; rowId_out = 0; max_h_out = 0; maxRowId_out = 0; maxColId_out = 0.
- Reset mid-operation clears all state immediately. There is no partial-cell completion.
- NEG_INF = -(2^(SCORE_W-2)). All add/sub results saturate to [NEG_INF, 2^(SCORE_W-1)-1].
- s is the substitution score: DNA gives +match_score when seq1 == seq2, else -mismatch_pen. Protein gives the BLOSUM50 value, sign-extended.
- Recurrences, computed each cycle:
  - D = h_diag + s
  - E = max(e_reg - gap_ext, h_out - gap_open) (Above)
  - F = max(f_left - gap_ext, h_left - gap_open) (Left)
  - H = max(D, E, F), then max with 0 if mode_local.
- Tie priority is Diagonal > Above > Left.
- Local mode: if the best candidate <= 0, H = 0 and pointer = Nil.
- e_ext = 1 when the extension term of E strictly exceeds the open term; f_ext likewise for F.
- enable = 1: register h_out <= H, e_reg <= E, f_out <= F, pointer_out, e_ext, f_ext.
- enable = 0 (idle/boundary):
  - h_out <= (mode_local ? 0 : h_bound)
  - e_reg <= NEG_INF; f_out <= NEG_INF; pointer_out <= Nil
  - max registers hold.
- Every cycle regardless of enable: h_diag <= h_left; enable_out <= enable; seq1_out <= seq1; rowId_out <= rowId_in.
- Max tracking, when enable = 1:
  - Candidates are own max_h_out, max_h_in, and (if valid_col) H with ids (rowId_in, colId_in).
  - The largest candidate wins. Ties keep the earlier source, priority max_h_out > max_h_in > new cell.
  - When enable = 0, max_h_in is still merged; the new cell is not.
- Config inputs must be stable while any PE is enabled. Changing them mid-stream is undefined.

Test Plan:
- Reset: assert rst mid-stream (h_out = 9) -> same-cycle h_out = 0, max_h_out = 0, enable_out = 0, f_out = -16384.
- DNA local match (SCORE_W = 16, match = 2, mismatch = 1, open = 3, ext = 1): prior h_left = 5, seq1 = seq2, h_out = 0, f_left = NEG_INF -> h_out = 7, pointer Diagonal.
- Affine extension: h_out = 10, then 3 enabled mismatch cycles with h_left = NEG_INF, h_diag = 0 -> h_out 7, 6, 5; pointer Above each cycle; e_ext 0, 1, 1.
- Mode: all mismatches with h_left = 0 -> local gives h_out = 0, Nil. Global with h_bound = -3 (idle one cycle first) gives h_out = -6, pointer Above.
- Saturation: h_diag = 32766 with match -> h_out = 32767. h_left = NEG_INF with gap_open = 3 -> F = -16384.
- Max tie: max_h_out = 8, max_h_in = 8 (different ids), new H = 8 with valid_col -> max ids unchanged. New H = 9 -> ids = (rowId_in, colId_in).
- Protein: ALPHABET = 1, seq1 = seq2 = W, h_diag = 0, local -> h_out = 15.
